zeroriscy_soc: RTL and testbench



---
 rtl/zeroriscy_soc_pkg.sv | 43 ++++
 rtl/soc_mem.sv | 41 ++++
 rtl/zeroriscy_core.sv | 222 ++++++++++++++++++++++
 rtl/zeroriscy_soc.sv | 142 ++++++++++++++
 tb/tb_zeroriscy_soc.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/zeroriscy_soc_pkg.sv
// Address map, region decode and byte-lane merge shared by the SoC wrapper.
// Latency: combinational helpers only.
// Backpressure: none; pure constants and functions.
package zeroriscy_soc_pkg;

  localparam logic [31:0] SOC_BOOT_ADDR       = 32'h0000_0000;
  localparam logic [31:0] SOC_RESET_PC_OFFSET = 32'h0000_0080;
  localparam logic [31:0] SOC_DMEM_BASE       = 32'h0000_1000;
  localparam logic [31:0] SOC_RESULT_ADDR     = 32'h0000_2000;
  localparam logic [31:0] SOC_FLAG_ADDR       = 32'h0000_2004;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_DMEM,
    REGION_RESULT,
    REGION_FLAG
  } region_e;

  // Classify a word-aligned data address into one of the SoC regions.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] dmem_base,
                                            input logic [31:0] dmem_bytes,
                                            input logic [31:0] result_addr,
                                            input logic [31:0] flag_addr);
    if (addr >= dmem_base && (addr - dmem_base) < dmem_bytes) return REGION_DMEM;
    if (addr == result_addr) return REGION_RESULT;
    if (addr == flag_addr) return REGION_FLAG;
    return REGION_NONE;
  endfunction

  // Replace the byte lanes of old selected by be with the lanes of wdata.
  function automatic logic [31:0] merge_be(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_mem.sv
// Single-port synchronous word RAM with per-byte write enables.
// Latency: grant in the request cycle, rvalid and registered rdata one cycle later.
// Backpressure: none; every request is granted immediately.
module soc_mem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          gnt,
  output logic          rvalid,
  output logic [31:0]   rdata
);

  // Contents are never reset; benches may preload them hierarchically.
  logic [31:0] mem [WORDS];

  assign gnt = req;

  // Byte-lane writes and registered reads; array deliberately has no reset.
  always_ff @(posedge clk) begin
    if (req && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (req && !we) rdata <= mem[addr];
  end

  // One-cycle response strobe for both reads and writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid <= 1'b0;
    else        rvalid <= req;
  end

endmodule

// File: rtl/zeroriscy_core.sv
// Compact multicycle RV32I core exposing the zero-riscy memory interface.
// Latency: fetch/wait/execute per instruction, plus request/wait for loads and stores.
// Backpressure: holds requests until granted and waits for rvalid on both ports.
module zeroriscy_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clock_en_i,
  input  logic        test_en_i,
  input  logic [3:0]  core_id_i,
  input  logic [5:0]  cluster_id_i,
  input  logic [31:0] boot_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        irq_i,
  input  logic [4:0]  irq_id_i,
  output logic        irq_ack_o,
  output logic [4:0]  irq_id_o,
  input  logic        debug_req_i,
  input  logic        fetch_enable_i,
  output logic        core_busy_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {S_FETCH, S_IWAIT, S_EXEC, S_DREQ, S_DWAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ls_addr_q, ls_addr_d;
  logic [31:0] rf [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, ld_shift, ld_val;
  logic        br_taken;

  // Interrupts, debug and identification inputs are not used by this core.
  logic unused_inputs;
  assign unused_inputs = ^{clock_en_i, test_en_i, core_id_i, cluster_id_i,
                           data_err_i, irq_i, irq_id_i, debug_req_i};

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? $signed(a) >>> b[4:0] : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  assign instr_addr_o = pc_q;
  assign data_we_o    = (opcode == OP_STORE);
  assign data_addr_o  = {ls_addr_q[31:2], 2'b00};
  assign irq_ack_o    = 1'b0;
  assign irq_id_o     = 5'd0;
  assign core_busy_o  = (state_q != S_FETCH);

  // Branch condition from the two source operands.
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Store lane steering and load extraction from the byte offset.
  always_comb begin
    data_be_o    = 4'hF;
    data_wdata_o = rs2_val;
    case (f3[1:0])
      2'b00: begin
        data_be_o    = 4'b0001 << ls_addr_q[1:0];
        data_wdata_o = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        data_be_o    = 4'b0011 << ls_addr_q[1:0];
        data_wdata_o = {2{rs2_val[15:0]}};
      end
      default: ;
    endcase
    ld_shift = data_rdata_i >> {ls_addr_q[1:0], 3'b000};
    case (f3)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_val = {24'd0, ld_shift[7:0]};
      3'b101:  ld_val = {16'd0, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  // Sequencer: next state, PC update, register writeback and bus requests.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ls_addr_d   = ls_addr_q;
    rf_we       = 1'b0;
    rf_wdata    = 32'd0;
    instr_req_o = 1'b0;
    data_req_o  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_enable_i) begin
          instr_req_o = 1'b1;
          if (instr_gnt_i) state_d = S_IWAIT;
        end
      end
      S_IWAIT: begin
        if (instr_rvalid_i) begin
          ir_d    = instr_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH;
        case (opcode)
          OP_LUI:    begin rf_we = 1'b1; rf_wdata = imm_u; end
          OP_AUIPC:  begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
          OP_JAL:    begin rf_we = 1'b1; rf_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
          OP_JALR:   begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + 32'd4;
            pc_d     = (rs1_val + imm_i) & ~32'd1;
          end
          OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
          OP_IMM:    begin
            rf_we    = 1'b1;
            rf_wdata = alu(rs1_val, imm_i, f3, (f3 == 3'b101) && ir_q[30]);
          end
          OP_REG:    begin rf_we = 1'b1; rf_wdata = alu(rs1_val, rs2_val, f3, ir_q[30]); end
          OP_LOAD:   begin pc_d = pc_q; ls_addr_d = rs1_val + imm_i; state_d = S_DREQ; end
          OP_STORE:  begin pc_d = pc_q; ls_addr_d = rs1_val + imm_s; state_d = S_DREQ; end
          default: ;
        endcase
      end
      S_DREQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = S_DWAIT;
      end
      S_DWAIT: begin
        if (data_rvalid_i) begin
          rf_we    = (opcode == OP_LOAD);
          rf_wdata = ld_val;
          pc_d     = pc_q + 32'd4;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural state; PC restarts at boot address plus the vector offset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      pc_q      <= boot_addr_i + 32'h80;
      ir_q      <= 32'd0;
      ls_addr_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      ls_addr_q <= ls_addr_d;
    end
  end

  // Register file writes; x0 stays hard-wired to zero.
  always_ff @(posedge clk_i) begin
    if (rf_we && rd != 5'd0) rf[rd] <= rf_wdata;
  end

endmodule

// File: rtl/zeroriscy_soc.sv
// Single-core SoC: core, instruction ROM, data RAM and result/flag status registers.
// Latency: both ports grant in the request cycle and respond one cycle later.
// Backpressure: none; instruction and data ports are served independently.
module zeroriscy_soc
  import zeroriscy_soc_pkg::*;
#(
  parameter int          IMEM_WORDS  = 256,
  parameter int          DMEM_WORDS  = 256,
  parameter logic [31:0] BOOT_ADDR   = SOC_BOOT_ADDR,
  parameter logic [31:0] DMEM_BASE   = SOC_DMEM_BASE,
  parameter logic [31:0] RESULT_ADDR = SOC_RESULT_ADDR,
  parameter logic [31:0] FLAG_ADDR   = SOC_FLAG_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  output logic [31:0] mem_flag,
  output logic [31:0] mem_result,
  output logic [31:0] instr_addr
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  logic          instr_req, instr_gnt, instr_rvalid;
  logic [31:0]   instr_rdata, imem_off;
  logic          data_req, data_gnt, data_rvalid, data_we;
  logic [3:0]    data_be;
  logic [31:0]   data_addr, data_wdata, data_rdata, dmem_off;
  logic          dmem_req, dmem_gnt, dmem_rvalid, dmem_sel;
  logic [31:0]   dmem_rdata;
  logic          reg_rvalid;
  logic [31:0]   reg_rdata;
  logic          irq_ack, core_busy;
  logic [4:0]    irq_id;
  region_e       region;

  zeroriscy_core core (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clock_en_i     (1'b1),
    .test_en_i      (1'b0),
    .core_id_i      (4'd0),
    .cluster_id_i   (6'd0),
    .boot_addr_i    (BOOT_ADDR),
    .instr_req_o    (instr_req),
    .instr_gnt_i    (instr_gnt),
    .instr_rvalid_i (instr_rvalid),
    .instr_addr_o   (instr_addr),
    .instr_rdata_i  (instr_rdata),
    .data_req_o     (data_req),
    .data_gnt_i     (data_gnt),
    .data_rvalid_i  (data_rvalid),
    .data_we_o      (data_we),
    .data_be_o      (data_be),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_rdata_i   (data_rdata),
    .data_err_i     (1'b0),
    .irq_i          (1'b0),
    .irq_id_i       (5'd0),
    .irq_ack_o      (irq_ack),
    .irq_id_o       (irq_id),
    .debug_req_i    (1'b0),
    .fetch_enable_i (fetch_enable_i),
    .core_busy_o    (core_busy)
  );

  // Word 0 of the instruction memory holds the instruction at the reset PC.
  assign imem_off = instr_addr - (BOOT_ADDR + SOC_RESET_PC_OFFSET);

  soc_mem #(.WORDS(IMEM_WORDS)) inst_mem (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (instr_req),
    .we     (1'b0),
    .be     (4'h0),
    .addr   (imem_off[IAW+1:2]),
    .wdata  (32'd0),
    .gnt    (instr_gnt),
    .rvalid (instr_rvalid),
    .rdata  (instr_rdata)
  );

  assign region   = decode_region(data_addr, DMEM_BASE, DMEM_BYTES, RESULT_ADDR, FLAG_ADDR);
  assign dmem_off = data_addr - DMEM_BASE;
  assign dmem_req = data_req && (region == REGION_DMEM);
  assign data_gnt = data_req;

  soc_mem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .req    (dmem_req),
    .we     (data_we),
    .be     (data_be),
    .addr   (dmem_off[DAW+1:2]),
    .wdata  (data_wdata),
    .gnt    (dmem_gnt),
    .rvalid (dmem_rvalid),
    .rdata  (dmem_rdata)
  );

  // Status registers take byte-lane writes and clear asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_result <= 32'd0;
      mem_flag   <= 32'd0;
    end else if (data_req && data_we) begin
      if (region == REGION_RESULT) mem_result <= merge_be(mem_result, data_wdata, data_be);
      if (region == REGION_FLAG)   mem_flag   <= merge_be(mem_flag, data_wdata, data_be);
    end
  end

  // Response path for non-RAM accesses; unmapped reads return zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_rvalid <= 1'b0;
      reg_rdata  <= 32'd0;
      dmem_sel   <= 1'b0;
    end else begin
      reg_rvalid <= data_req && (region != REGION_DMEM);
      dmem_sel   <= dmem_req;
      if (data_req && !data_we) begin
        case (region)
          REGION_RESULT: reg_rdata <= mem_result;
          REGION_FLAG:   reg_rdata <= mem_flag;
          default:       reg_rdata <= 32'd0;
        endcase
      end
    end
  end

  assign data_rvalid = dmem_rvalid | reg_rvalid;
  assign data_rdata  = dmem_sel ? dmem_rdata : reg_rdata;

  // Address bits beyond the memory index and spare core outputs are not needed.
  logic unused_bits;
  assign unused_bits = ^{imem_off[31:IAW+2], imem_off[1:0], dmem_off[31:DAW+2],
                         dmem_off[1:0], dmem_gnt, irq_ack, irq_id, core_busy};

endmodule

// File: tb/tb_zeroriscy_soc.sv
module tb_zeroriscy_soc;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_enable_i = 1'b1;
  logic [31:0] mem_flag, mem_result, instr_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #2 clk_i = ~clk_i;

  zeroriscy_soc dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_enable_i (fetch_enable_i),
    .mem_flag       (mem_flag),
    .mem_result     (mem_result),
    .instr_addr     (instr_addr)
  );

  // li t0,0x37 / sw RESULT / li t0,1 / sw FLAG / spin
  logic [31:0] prog_store[$] = '{32'h00002337, 32'h03700293, 32'h00532023,
                                 32'h00100293, 32'h00532223, 32'h0000006F};
  // word store, byte store, RAM round trip, unmapped read, result readback
  logic [31:0] prog_be[$] = '{32'h00002337, 32'hAABBD2B7, 32'hCDD28293, 32'h00532023,
                              32'h01100393, 32'h007300A3, 32'h00001437, 32'h00542423,
                              32'h00842483, 32'h00002503, 32'h00A484B3, 32'h00032583,
                              32'h00B4C4B3, 32'h00932223, 32'h0000006F};
  // F(10) iteratively, store to RESULT, then flag=1
  logic [31:0] prog_fib[$] = '{32'h00000293, 32'h00100393, 32'h00A00E13, 32'h00002337,
                               32'h00728EB3, 32'h00038293, 32'h000E8393, 32'hFFFE0E13,
                               32'hFE0E18E3, 32'h00532023, 32'h00100293, 32'h00532223,
                               32'h0000006F};
  // read RAM word left by an earlier program and publish it
  logic [31:0] prog_keep[$] = '{32'h00001437, 32'h00842483, 32'h00002337, 32'h00932023,
                                32'h00100293, 32'h00532223, 32'h0000006F};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 256; i++)
      dut.inst_mem.mem[i] = (i < p.size()) ? p[i] : 32'h0000006F;
  endtask

  // Wait until the selected status register differs from 'from', bounded.
  task automatic wait_change(input bit sel_flag, input logic [31:0] from,
                             input int max_cycles, output logic [31:0] ok);
    ok = 32'd0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_i);
      if ((sel_flag ? mem_flag : mem_result) !== from) begin
        ok = 32'd1;
        break;
      end
    end
  endtask

  task automatic reset_and_release(input logic fe);
    @(negedge clk_i);
    rst_ni = 1'b0;
    fetch_enable_i = fe;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  logic [31:0] ok, worst_addr, flag_or;

  initial begin
    // Power-on reset with a preloaded store program.
    load_prog(prog_store);
    #5;
    check_eq("rst_flag", mem_flag, 32'd0);
    check_eq("rst_result", mem_result, 32'd0);
    check_eq("rst_pc", instr_addr, 32'h80);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_eq("first_fetch", instr_addr, 32'h80);
    wait_change(1'b0, 32'd0, 40, ok);
    check_eq("store_res_done", ok, 32'd1);
    check_eq("store_result", mem_result, 32'h37);
    check_eq("store_flag_order", mem_flag, 32'd0);
    wait_change(1'b1, 32'd0, 40, ok);
    check_eq("store_flag_done", ok, 32'd1);
    check_eq("store_flag", mem_flag, 32'd1);
    repeat (6) @(negedge clk_i);
    check_eq("store_spin_pc", instr_addr, 32'h94);

    // Asynchronous reset mid-cycle, then hold fetch disabled.
    @(negedge clk_i);
    fetch_enable_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_eq("async_flag", mem_flag, 32'd0);
    check_eq("async_result", mem_result, 32'd0);
    check_eq("async_pc", instr_addr, 32'h80);
    @(negedge clk_i);
    rst_ni = 1'b1;
    worst_addr = 32'h80;
    flag_or = 32'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (instr_addr !== 32'h80) worst_addr = instr_addr;
      flag_or = flag_or | mem_flag | mem_result;
    end
    check_eq("idle_pc", worst_addr, 32'h80);
    check_eq("idle_status", flag_or, 32'd0);
    fetch_enable_i = 1'b1;
    check_eq("enable_pc", instr_addr, 32'h80);
    wait_change(1'b1, 32'd0, 40, ok);
    check_eq("enable_done", ok, 32'd1);
    check_eq("enable_result", mem_result, 32'h37);

    // Byte enables on the result register, RAM round trip, unmapped read.
    rst_ni = 1'b0;
    load_prog(prog_be);
    reset_and_release(1'b1);
    wait_change(1'b0, 32'd0, 40, ok);
    check_eq("be_word_done", ok, 32'd1);
    check_eq("be_word", mem_result, 32'hAABBCCDD);
    wait_change(1'b0, 32'hAABBCCDD, 20, ok);
    check_eq("be_byte_done", ok, 32'd1);
    check_eq("be_byte", mem_result, 32'hAABB11DD);
    wait_change(1'b1, 32'd0, 100, ok);
    check_eq("be_flag_done", ok, 32'd1);
    check_eq("be_flag", mem_flag, 32'h0000DD00);

    // Fibonacci run, bounded to 250 cycles (1000 time units).
    rst_ni = 1'b0;
    load_prog(prog_fib);
    reset_and_release(1'b1);
    wait_change(1'b1, 32'd0, 250, ok);
    check_eq("fib_done", ok, 32'd1);
    check_eq("fib_result", mem_result, 32'd55);
    check_eq("fib_flag", mem_flag, 32'd1);
    repeat (6) @(negedge clk_i);
    check_eq("fib_spin_pc", instr_addr, 32'hB0);

    // Reset in the middle of the loop, then rerun to the same answer.
    reset_and_release(1'b1);
    repeat (60) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_pc", instr_addr, 32'h80);
    check_eq("mid_result", mem_result, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_change(1'b1, 32'd0, 250, ok);
    check_eq("rerun_done", ok, 32'd1);
    check_eq("rerun_result", mem_result, 32'd55);

    // Data RAM keeps its contents across reset.
    rst_ni = 1'b0;
    load_prog(prog_keep);
    reset_and_release(1'b1);
    wait_change(1'b1, 32'd0, 60, ok);
    check_eq("keep_done", ok, 32'd1);
    check_eq("keep_result", mem_result, 32'hAABBCCDD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
